// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4 read-channel arbiter.
// Optional feature macro: AXI_READ_ARB_RR_EN (round-robin grant policy).
package axi_arb_pkg;

  localparam int AXI_LEN_W = 8;

  // Arbiter sequencing: wait for a request, forward one AR, then stream R beats.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // AXI burst type encodings.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Number of beats in a burst; arlen = 255 needs the ninth bit.
  function automatic logic [AXI_LEN_W:0] burst_beats(input logic [AXI_LEN_W-1:0] len);
    return {1'b0, len} + 9'd1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_pick2.sv
// Two-way grant selection for axi_read_arbiter.
// Optional feature macro: AXI_READ_ARB_RR_EN selects round-robin on ties;
// otherwise master 0 always wins ties and the pointer input is ignored.
module arb_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       winner_o
);

`ifdef AXI_READ_ARB_RR_EN
  // Tie goes to the master named by the pointer; a lone request always wins.
  always_comb begin
    winner_o = 1'b0;
    if (req_i == 2'b11) begin
      winner_o = ptr_i;
    end else begin
      winner_o = req_i[1] & ~req_i[0];
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  // Master 0 wins whenever it requests.
  always_comb begin
    winner_o = req_i[1] & ~req_i[0];
  end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read-channel arbiter in front of a single RAM read port.
// One master owns the slave from grant until the R beat carrying rlast.
// Optional feature macro: AXI_READ_ARB_RR_EN (round-robin instead of fixed
// priority with master 0 winning ties).
//
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid is never gated by ready, and AR/R paths are pure combinational
// pass-through to and from the granted master.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  // master 0
  input  logic [ADDRESS_WIDTH-1:0] m0_araddr,
  input  logic [AXI_LEN_W-1:0]     m0_arlen,
  input  logic [2:0]               m0_arsize,
  input  logic [1:0]               m0_arburst,
  input  logic                     m0_arvalid,
  output logic                     m0_arready,
  output logic [DATA_WIDTH-1:0]    m0_rdata,
  output logic [1:0]               m0_rresp,
  output logic                     m0_rlast,
  output logic                     m0_rvalid,
  input  logic                     m0_rready,
  // master 1
  input  logic [ADDRESS_WIDTH-1:0] m1_araddr,
  input  logic [AXI_LEN_W-1:0]     m1_arlen,
  input  logic [2:0]               m1_arsize,
  input  logic [1:0]               m1_arburst,
  input  logic                     m1_arvalid,
  output logic                     m1_arready,
  output logic [DATA_WIDTH-1:0]    m1_rdata,
  output logic [1:0]               m1_rresp,
  output logic                     m1_rlast,
  output logic                     m1_rvalid,
  input  logic                     m1_rready,
  // slave
  output logic [ADDRESS_WIDTH-1:0] s_araddr,
  output logic [AXI_LEN_W-1:0]     s_arlen,
  output logic [2:0]               s_arsize,
  output logic [1:0]               s_arburst,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [DATA_WIDTH-1:0]    s_rdata,
  input  logic [1:0]               s_rresp,
  input  logic                     s_rlast,
  input  logic                     s_rvalid,
  output logic                     s_rready,
  // status
  output logic                     grant_id,
  output logic                     busy,
  output logic                     len_err,
  output logic [1:0]               dbg_state_o
);

  arb_state_e          state_q;
  logic                grant_q;
  logic [AXI_LEN_W:0]  beats_left_q;
  logic                len_err_q;
  logic                winner;
  logic                ptr;
  logic                in_addr;
  logic                in_data;
  logic                ar_hs;
  logic                r_hs;
  logic [AXI_LEN_W-1:0] g_arlen;

`ifdef AXI_READ_ARB_RR_EN
  logic ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  arb_pick2 u_pick (
    .req_i    ({m1_arvalid, m0_arvalid}),
    .ptr_i    (ptr),
    .winner_o (winner)
  );

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);

  // AR path: granted master's fields go straight to the slave.
  assign s_araddr  = grant_q ? m1_araddr  : m0_araddr;
  assign g_arlen   = grant_q ? m1_arlen   : m0_arlen;
  assign s_arlen   = g_arlen;
  assign s_arsize  = grant_q ? m1_arsize  : m0_arsize;
  assign s_arburst = grant_q ? m1_arburst : m0_arburst;
  assign s_arvalid = in_addr & (grant_q ? m1_arvalid : m0_arvalid);
  assign m0_arready = in_addr & ~grant_q & s_arready;
  assign m1_arready = in_addr &  grant_q & s_arready;

  // R path: payload is broadcast, valid only reaches the owner.
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m1_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rlast  = s_rlast;
  assign m0_rvalid = in_data & ~grant_q & s_rvalid;
  assign m1_rvalid = in_data &  grant_q & s_rvalid;
  assign s_rready  = in_data & (grant_q ? m1_rready : m0_rready);

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign len_err     = len_err_q;
  assign dbg_state_o = state_q;

  // Grant / address / data sequencing with burst-length checking on each R beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      beats_left_q <= '0;
      len_err_q    <= 1'b0;
`ifdef AXI_READ_ARB_RR_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            grant_q <= winner;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            beats_left_q <= burst_beats(g_arlen);
            state_q      <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (beats_left_q != '0) begin
              beats_left_q <= beats_left_q - 9'd1;
            end
            // rlast must coincide exactly with the final expected beat.
            len_err_q <= s_rlast ^ (beats_left_q == 9'd1);
            if (s_rlast) begin
              state_q <= IDLE;
`ifdef AXI_READ_ARB_RR_EN
              ptr_q   <= ~grant_q;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed testbench for axi_read_arbiter with a cycle-level reference model.
// Honours AXI_READ_ARB_RR_EN for the expected grant order.
module tb_axi_read_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] m_araddr [2];
  logic [7:0]    m_arlen  [2];
  logic [2:0]    m_arsize [2];
  logic [1:0]    m_arburst[2];
  logic          m_arvalid[2];
  logic          m_arready[2];
  logic [DW-1:0] m_rdata  [2];
  logic [1:0]    m_rresp  [2];
  logic          m_rlast  [2];
  logic          m_rvalid [2];
  logic          m_rready [2];
  logic [AW-1:0] s_araddr;
  logic [7:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic [1:0]    s_arburst;
  logic          s_arvalid, s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast, s_rvalid, s_rready;
  logic          grant_id, busy, len_err;
  logic [1:0]    dbg_state;

  axi_read_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]),
    .m0_arburst(m_arburst[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]),
    .m1_arburst(m_arburst[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy), .len_err(len_err), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 aclk = ~aclk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  int         cyc = 0;
  logic       rr_toggle[2];
  int         last_at_ovr = -1;   // slave rlast beat override for the next burst
  logic       sl_active;
  logic [8:0] sl_beat;
  logic [7:0] sl_addr;
  int         sl_last_at;
  // handshakes observed during the previous cycle
  logic       f_ar_hs, f_r_hs, f_r_last;
  logic [7:0] f_araddr, f_arlen;
  logic       f_mar_hs[2];

  // scoreboard: expected AR order as {master, araddr}
  logic [8:0] exp_q[$];
  int rhs_cnt[2];
  int rv_cnt[2];
  int err_cnt;
  int bursts_done;

  // ---------------- slave and master driver ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = '0; m_arlen[i] = '0; m_arsize[i] = '0; m_arburst[i] = '0;
      m_arvalid[i] = 1'b0; m_rready[i] = 1'b1; rr_toggle[i] = 1'b0; f_mar_hs[i] = 1'b0;
    end
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    sl_active = 1'b0; sl_beat = '0; sl_addr = '0; sl_last_at = 0;
    f_ar_hs = 1'b0; f_r_hs = 1'b0; f_r_last = 1'b0; f_araddr = '0; f_arlen = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        sl_active = 1'b0; sl_beat = '0;
        m_arvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) if (f_mar_hs[i]) m_arvalid[i] = 1'b0;
        if (f_r_hs) begin
          sl_beat++;
          if (f_r_last) sl_active = 1'b0;
        end
        if (f_ar_hs) begin
          sl_active  = 1'b1;
          sl_beat    = '0;
          sl_addr    = f_araddr;
          sl_last_at = (last_at_ovr >= 0) ? last_at_ovr : int'(f_arlen);
          last_at_ovr = -1;
        end
      end
      s_arready = (cyc % 3) != 0;
      s_rvalid  = sl_active;
      s_rdata   = sl_active ? {sl_addr, 15'h0, sl_beat} : '0;
      s_rresp   = sl_active ? {sl_beat[0], 1'b0} : 2'b00;
      s_rlast   = sl_active && (int'(sl_beat) == sl_last_at);
      for (int i = 0; i < 2; i++) m_rready[i] = rr_toggle[i] ? cyc[0] : 1'b1;
    end
  end

  // ---------------- reference model and compare ----------------
  int   ph = 0;        // 0 idle, 1 address phase, 2 data phase
  logic own = 1'b0;    // master owning the slave
  logic ptr = 1'b0;    // master favoured on a tie
  int   beats = 0;     // beats still expected in the burst
  logic exp_err = 1'b0;

  initial begin
    forever begin
      @(negedge aclk);
      #1;
      if (!aresetn) begin
        ph = 0; own = 1'b0; ptr = 1'b0; beats = 0; exp_err = 1'b0;
      end
      chk("busy", busy, ph != 0);
      chk("grant_id", grant_id, own);
      chk("len_err", len_err, exp_err);
      chk("s_arvalid", s_arvalid, ph == 1 && m_arvalid[own]);
      chk("s_rready", s_rready, ph == 2 && m_rready[own]);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_arready", i), m_arready[i], ph == 1 && own == i[0] && s_arready);
        chk($sformatf("m%0d_rvalid", i), m_rvalid[i], ph == 2 && own == i[0] && s_rvalid);
        if (ph == 2)
          chk($sformatf("m%0d_r_bcast", i), {m_rdata[i], m_rresp[i], m_rlast[i]},
              {s_rdata, s_rresp, s_rlast});
      end
      if (ph == 1)
        chk("s_ar_fields", {s_araddr, s_arlen, s_arsize, s_arburst},
            {m_araddr[own], m_arlen[own], m_arsize[own], m_arburst[own]});

      // record handshakes for the driver
      f_ar_hs  = s_arvalid && s_arready;
      f_araddr = s_araddr;
      f_arlen  = s_arlen;
      f_r_hs   = s_rvalid && s_rready;
      f_r_last = s_rlast;
      for (int i = 0; i < 2; i++) f_mar_hs[i] = m_arvalid[i] && m_arready[i];

      // scoreboard and counters
      if (aresetn && f_ar_hs) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: got {%0d,%0h} expected none at %0t",
                   m_arready[1], s_araddr, $time);
        end else begin
          chk("ar_order", {m_arready[1], s_araddr}, exp_q.pop_front());
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (m_rvalid[i] && m_rready[i]) rhs_cnt[i]++;
        if (m_rvalid[i]) rv_cnt[i]++;
      end
      if (len_err) err_cnt++;
      if (aresetn && f_r_hs && f_r_last) bursts_done++;

      // advance the model by one clock
      if (aresetn) begin
        exp_err = 1'b0;
        case (ph)
          0: if (m_arvalid[0] || m_arvalid[1]) begin
               ph = 1;
               if (m_arvalid[0] && m_arvalid[1]) begin
`ifdef AXI_READ_ARB_RR_EN
                 own = ptr;
`else
                 own = 1'b0;
`endif
               end else begin
                 own = m_arvalid[1];
               end
             end
          1: if (m_arvalid[own] && s_arready) begin
               ph = 2;
               beats = int'(m_arlen[own]) + 1;
             end
          2: if (s_rvalid && m_rready[own]) begin
               exp_err = (s_rlast != (beats == 1));
               beats--;
               if (s_rlast) begin
                 ph = 0;
                 ptr = !own;
               end
             end
          default: ph = 0;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req(input int i, input logic [7:0] addr, input logic [7:0] len);
    m_araddr[i]  = addr;
    m_arlen[i]   = len;
    m_arsize[i]  = 3'd2;
    m_arburst[i] = 2'b01;
    m_arvalid[i] = 1'b1;
  endtask

  task automatic clear_counts();
    rhs_cnt[0] = 0; rhs_cnt[1] = 0; rv_cnt[0] = 0; rv_cnt[1] = 0;
    err_cnt = 0; bursts_done = 0;
  endtask

  task automatic wait_bursts(input string name, input int n, input int budget);
    int k = 0;
    while (bursts_done < n && k < budget) begin
      @(negedge aclk);
      k++;
    end
    chk({name, "_bursts"}, bursts_done, n);
    repeat (3) @(negedge aclk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear_counts();
    repeat (3) @(negedge aclk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_valids", {s_arvalid, s_rready, m_arready[0], m_arready[1], m_rvalid[0], m_rvalid[1]}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // m0 single read, 4 beats
    clear_counts();
    exp_q.push_back({1'b0, 8'h10});
    req(0, 8'h10, 8'd3);
    wait_bursts("t1", 1, 100);
    chk("t1_m0_beats", rhs_cnt[0], 4);
    chk("t1_m1_beats", rhs_cnt[1], 0);
    chk("t1_len_err", err_cnt, 0);
    chk("t1_ar_left", exp_q.size(), 0);
    chk("t1_idle", busy, 0);

    // simultaneous requests; last winner was m0
    clear_counts();
`ifdef AXI_READ_ARB_RR_EN
    exp_q.push_back({1'b1, 8'h21});
    exp_q.push_back({1'b0, 8'h20});
`else
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b1, 8'h21});
`endif
    req(0, 8'h20, 8'd1);
    req(1, 8'h21, 8'd2);
    wait_bursts("t2", 2, 200);
    chk("t2_m0_beats", rhs_cnt[0], 2);
    chk("t2_m1_beats", rhs_cnt[1], 3);
    chk("t2_len_err", err_cnt, 0);
    chk("t2_ar_left", exp_q.size(), 0);

    // m1 256-beat burst with rready toggling
    clear_counts();
    rr_toggle[1] = 1'b1;
    exp_q.push_back({1'b1, 8'h30});
    req(1, 8'h30, 8'd255);
    wait_bursts("t3", 1, 2000);
    rr_toggle[1] = 1'b0;
    chk("t3_m1_beats", rhs_cnt[1], 256);
    chk("t3_m0_rvalid", rv_cnt[0], 0);
    chk("t3_len_err", err_cnt, 0);

    // early rlast on beat 2 of 4
    clear_counts();
    last_at_ovr = 1;
    exp_q.push_back({1'b0, 8'h40});
    req(0, 8'h40, 8'd3);
    wait_bursts("t4", 1, 100);
    chk("t4_m0_beats", rhs_cnt[0], 2);
    chk("t4_len_err_pulses", err_cnt, 1);
    chk("t4_idle", busy, 0);

    // reset during beat 5 of 8
    clear_counts();
    exp_q.push_back({1'b0, 8'h50});
    req(0, 8'h50, 8'd7);
    for (int k = 0; k < 200; k++) begin
      @(negedge aclk);
      #2;
      if (sl_active && sl_beat == 9'd4) break;
    end
    chk("t5_reached_beat5", {sl_active, sl_beat}, {1'b1, 9'd4});
    #1 aresetn = 1'b0;
    #1;
    chk("t5_async_valids", {s_arvalid, s_rready, m_arready[0], m_arready[1], m_rvalid[0], m_rvalid[1]}, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_state", dbg_state, 0);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    clear_counts();
    exp_q.push_back({1'b0, 8'h60});
    req(0, 8'h60, 8'd1);
    wait_bursts("t5", 1, 100);
    chk("t5_m0_beats", rhs_cnt[0], 2);
    chk("t5_len_err", err_cnt, 0);
    chk("t5_ar_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master AXI4 read-channel arbiter that shares the single read port of the block RAM slave between two requesters. It grants one master at a time, routes that master's AR transfer to the slave, and routes the slave's R beats back until the burst's last beat completes. It also checks burst length against `rlast` and flags mismatches. It sits between the interconnect masters and the RAM slave's `ar*`/`r*` ports; write channels bypass it.

## Interface
Parameters:
- `DATA_WIDTH`, 32, R data width
- `ADDRESS_WIDTH`, 8, AR address width

Ports (`mN_` means one port per master, N = 0, 1):
- `aclk`  in  1  clock
- `aresetn`  in  1  reset, asynchronous assert, active-low
- `mN_araddr`  in  ADDRESS_WIDTH  master read address
- `mN_arlen`  in  8  beats minus 1
- `mN_arsize`  in  3  beat size
- `mN_arburst`  in  2  burst type
- `mN_arvalid`  in  1  AR valid
- `mN_arready`  out  1  AR ready
- `mN_rdata`  out  DATA_WIDTH  read data, broadcast to both masters
- `mN_rresp`  out  2  response, broadcast
- `mN_rlast`  out  1  last beat, broadcast
- `mN_rvalid`  out  1  R valid, granted master only
- `mN_rready`  in  1  R ready
- `s_araddr`, `s_arlen`, `s_arsize`, `s_arburst`, `s_arvalid`  out  as master side  to slave
- `s_arready`  in  1  slave AR ready
- `s_rdata`, `s_rresp`, `s_rlast`, `s_rvalid`  in  as master side  from slave
- `s_rready`  out  1  to slave
- `grant_id`  out  1  currently or last granted master
- `busy`  out  1  state is not IDLE
- `len_err`  out  1  one-cycle pulse on a burst-length mismatch

## Operation
- State machine has three states: IDLE, ADDR, DATA.
- **IDLE**
  - All `mN_arready`, `mN_rvalid`, `s_arvalid` and `s_rready` are 0.
  - If any `mN_arvalid` is set, pick the winner per the policy in Configuration.
  - Register the winner in `grant_id` and go to ADDR.
- **ADDR**
  - Combinationally pass the granted master's `ar*` fields to `s_ar*`, with `s_arvalid = m[g]_arvalid`.
  - Drive `m[g]_arready = s_arready`. The other master's `arready` is 0.
  - On `s_arvalid && s_arready`: load `beats_left` (9 bits) with `{1'b0, arlen} + 1` and go to DATA.
- **DATA**
  - Drive `m[g]_rvalid = s_rvalid` and `s_rready = m[g]_rready`. The other master's `rvalid` is 0.
  - Each R handshake decrements `beats_left`.
  - On a handshake with `s_rlast = 1`, go to IDLE.
  - If `s_rlast` disagrees with `beats_left == 1` on any handshake, pulse `len_err`.
  - A mismatch does not change sequencing: the FSM still exits only on `rlast`.
- A master that drops `arvalid` in ADDR before the handshake is illegal AXI and is not checked. The FSM waits.

## Timing
- Reset: state is IDLE; `grant_id`, `busy`, `len_err` and `beats_left` are 0; all valid/ready outputs are 0.
- Reset mid-burst: the FSM aborts to IDLE immediately, and the slave is expected to be reset with it.
- There is one cycle of arbitration bubble: `arvalid` seen in IDLE gives `s_arvalid` on the next cycle.
- AR and R paths add zero latency: they are combinational pass-through.
- Back-to-back bursts: DATA→IDLE→ADDR, so at least one idle cycle separates the last R beat and the next AR.
- `arlen = 255` gives 256 beats, so `beats_left` needs 9 bits and must not overflow.
- Simultaneous requests in IDLE: exactly one grant. The loser keeps `arvalid` high and is served next.

## Configuration
- `AXI_READ_ARB_RR_EN` defined:
  - Round-robin policy. A 1-bit priority pointer is set to `~grant_id` on each DATA→IDLE exit.
  - The pointer resets to master 0.
- Not defined:
  - Fixed priority: master 0 always wins ties.
  - There is no pointer register.

## Structure
- Package `axi_arb_pkg` holds:
  - the state enum (IDLE, ADDR, DATA);
  - `AXI_LEN_W = 8`;
  - burst type constants (FIXED, INCR, WRAP).
- Sub-module `arb_pick2` holds the grant selection logic (fixed or round-robin, `ifdef` inside). Inputs: requests and pointer. Output: winner.

## Test plan
- m0 single read, `arlen = 3`: the slave sees one AR with `araddr` passed through, m0 gets 4 beats, `rlast` arrives on beat 4, then back to IDLE, `len_err = 0`.
- m0 and m1 request in the same IDLE cycle:
  - With RR: m0 is served first, then m1.
  - Second round of simultaneous requests: RR grants m1 first; fixed priority grants m0 first.
- m1 burst with `arlen = 255` and `rready` toggling every cycle: exactly 256 R handshakes, no `len_err`, and m0 `rvalid` stays 0 throughout.
- Slave asserts `s_rlast` on beat 2 of an `arlen = 3` burst: `len_err` pulses one cycle and the FSM returns to IDLE.
- `aresetn` asserted mid-DATA on beat 5 of 8: all valid/ready outputs are 0 in the same cycle (async), and after release a new m0 request is granted normally.
